// File: rtl/umi_write_sched.sv
// Round-robin scheduler sharing one UMI request channel among N requesters, with a
// single-entry registered output stage and a cap on outstanding non-posted writes.
module umi_write_sched #(
  parameter int unsigned N      = 4,
  parameter int unsigned CW     = 32,
  parameter int unsigned PW     = 256,
  parameter int unsigned MAXOUT = 8,
  parameter int unsigned OW     = $clog2(MAXOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_valid,
  input  logic [N*PW-1:0]   in_packet,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [PW-1:0]     out_packet,
  input  logic              out_ready,
  input  logic              resp_done,
  output logic [OW-1:0]     outstanding,
  output logic              resp_err
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

  // UMI request opcodes live in command[4:0]
  localparam logic [4:0] OpReqWrite  = 5'h03;
  localparam logic [4:0] OpReqPosted = 5'h05;

  typedef struct packed {
    logic write;
    logic write_posted;
  } umi_write_t;

  // Equivalent of the umi_write decoder on command[7:0]
  function automatic umi_write_t umi_write(input logic [7:0] command);
    umi_write_t r;
    r.write        = (command[4:0] == OpReqWrite);
    r.write_posted = (command[4:0] == OpReqPosted);
    return r;
  endfunction

  logic [RW-1:0] rr_q, rr_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_packet_q, out_packet_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          resp_err_q, resp_err_d;

  logic [N-1:0]  nonposted;
  logic [N-1:0]  eligible;
  logic [N-1:0]  grant;
  logic [RW-1:0] gidx;
  logic          found;
  logic          load;
  logic          at_limit;
  logic          accept;
  logic          inc;
  logic          dec;

  assign at_limit = (outstanding_q == OW'(MAXOUT));
  assign load     = ~out_valid_q | out_ready;

  always_comb begin
    nonposted = '0;
    eligible  = '0;
    for (int i = 0; i < N; i++) begin
      nonposted[i] = umi_write(in_packet[i*PW +: 8]).write;
      eligible[i]  = in_valid[i] & ~(nonposted[i] & at_limit);
    end
  end

  // Search from rr upward with wrap; grants only while the output stage can load
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % N;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gidx  = RW'(idx);
      end
    end
    if (found && load) grant[gidx] = 1'b1;
  end

  assign in_ready = grant;
  assign accept   = found & load;
  assign inc      = accept & nonposted[gidx];
  assign dec      = resp_done & (outstanding_q != '0);

  always_comb begin
    rr_d          = rr_q;
    out_valid_d   = out_valid_q;
    out_packet_d  = out_packet_q;
    outstanding_d = outstanding_q;
    resp_err_d    = resp_err_q | (resp_done & (outstanding_q == '0));

    if (accept) begin
      out_valid_d  = 1'b1;
      out_packet_d = in_packet[int'(gidx)*PW +: PW];
      rr_d         = (gidx == RW'(N - 1)) ? '0 : gidx + RW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (inc && !dec && !at_limit) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (dec && !inc) begin
      outstanding_d = outstanding_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q          <= '0;
      out_valid_q   <= 1'b0;
      out_packet_q  <= '0;
      outstanding_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      out_valid_q   <= out_valid_d;
      out_packet_q  <= out_packet_d;
      outstanding_q <= outstanding_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_packet  = out_packet_q;
  assign outstanding = outstanding_q;
  assign resp_err    = resp_err_q;

endmodule
